// File: rtl/mem_queue_split.sv
// rtl/mem_queue_split.sv - RVV load/store queue splitting wide beats onto a narrow memory bus
//
// Purpose: buffers RVV load requests, load data and stores in FIFOs, splits each
// RVV beat into R = RVV_DATA_WIDTH/MBUS_DATA_WIDTH bus beats, limits outstanding
// reads, skips all-zero-strobe store beats and reports completion and write errors.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   mbus_ar_* / mbus_r_*                read address / read data channels
//   mbus_aw_* / mbus_w_* / mbus_b_*     write address / write data / write response
//   rvv_addr_out, rvv_req_out           load request from the vector unit
//   rvv_data_out, rvv_be_out, rvv_valid_out   store from the vector unit
//   rvv_ready_out, rvv_data_in, rvv_valid_in  load data back to the vector unit
//   rvv_ld_full, rvv_st_full            request / store FIFO full
//   rvv_done_ld, rvv_done_st, rvv_st_err     completion pulses and sticky write error
module mem_queue_split #(
    parameter int MBUS_ADDR_WIDTH = 32,
    parameter int MBUS_DATA_WIDTH = 32,
    parameter int MBUS_DW_B       = MBUS_DATA_WIDTH >> 3,
    parameter int RVV_DATA_WIDTH  = 64,
    parameter int RVV_DW_B        = RVV_DATA_WIDTH >> 3,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [MBUS_ADDR_WIDTH-1:0] mbus_ar_addr,
    output logic                       mbus_ar_valid,
    input  logic                       mbus_ar_ready,
    input  logic [MBUS_DATA_WIDTH-1:0] mbus_r_data,
    input  logic                       mbus_r_valid,
    output logic                       mbus_r_ready,
    output logic [MBUS_ADDR_WIDTH-1:0] mbus_aw_addr,
    output logic                       mbus_aw_valid,
    input  logic                       mbus_aw_ready,
    output logic [MBUS_DATA_WIDTH-1:0] mbus_w_data,
    output logic [MBUS_DW_B-1:0]       mbus_w_strb,
    output logic                       mbus_w_valid,
    input  logic                       mbus_w_ready,
    input  logic [1:0]                 mbus_b_resp,
    input  logic                       mbus_b_valid,
    output logic                       mbus_b_ready,
    input  logic [MBUS_ADDR_WIDTH-1:0] rvv_addr_out,
    input  logic                       rvv_req_out,
    input  logic [RVV_DATA_WIDTH-1:0]  rvv_data_out,
    input  logic [RVV_DW_B-1:0]        rvv_be_out,
    input  logic                       rvv_valid_out,
    input  logic                       rvv_ready_out,
    output logic [RVV_DATA_WIDTH-1:0]  rvv_data_in,
    output logic                       rvv_valid_in,
    output logic                       rvv_ld_full,
    output logic                       rvv_st_full,
    output logic                       rvv_done_ld,
    output logic                       rvv_done_st,
    output logic                       rvv_st_err
);
    localparam int R     = RVV_DATA_WIDTH / MBUS_DATA_WIDTH;
    localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
    localparam int CNT_W = FIFO_DEPTH_BITS + $clog2(R) + 1;
    localparam int PTR_W = FIFO_DEPTH_BITS + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(R - 1);

    // Storage arrays (not reset; validity comes from the pointers)
    logic [MBUS_ADDR_WIDTH-1:0] req_mem     [DEPTH];
    logic [RVV_DATA_WIDTH-1:0]  ldf_mem     [DEPTH];
    logic [MBUS_ADDR_WIDTH-1:0] st_addr_mem [DEPTH];
    logic [RVV_DATA_WIDTH-1:0]  st_data_mem [DEPTH];
    logic [RVV_DW_B-1:0]        st_be_mem   [DEPTH];

    logic [PTR_W-1:0] req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [PTR_W-1:0] ldf_wr_q, ldf_wr_d, ldf_rd_q, ldf_rd_d;
    logic [PTR_W-1:0] st_wr_q, st_wr_d, st_rd_q, st_rd_d;
    logic [IDX_W-1:0] ar_idx_q, ar_idx_d, r_idx_q, r_idx_d, st_idx_q, st_idx_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] infl_q, infl_d;
    logic [CNT_W-1:0] ld_req_q, ld_req_d, ld_del_q, ld_del_d, wr_q, wr_d, ack_q, ack_d;
    logic [CNT_W-1:0] ld_req_nxt, ld_del_nxt, wr_nxt, ack_nxt;
    logic [RVV_DATA_WIDTH-1:0] asm_q, asm_d;
    logic done_ld_q, done_ld_d, done_st_q, done_st_d, st_err_q, st_err_d;

    logic [PTR_W-1:0] ldf_occ;
    logic req_empty, ldf_empty, st_empty, st_full;
    logic req_push, ldf_push, st_push, req_pop, ldf_pop, st_pop;
    logic ar_room, ar_hs, ar_start, r_hs, st_hs, b_hs;
    logic st_pend, st_more;
    logic [IDX_W-1:0] st_cur;
    logic [RVV_DW_B-1:0] st_be_h;

    // ---------------- load path ----------------
    assign req_empty   = (req_wr_q == req_rd_q);
    assign rvv_ld_full = ((req_wr_q - req_rd_q) == PTR_W'(DEPTH));
    assign req_push    = rvv_req_out && !rvv_ld_full;

    assign ldf_occ   = ldf_wr_q - ldf_rd_q;
    assign ldf_empty = (ldf_wr_q == ldf_rd_q);

    // A new AR sequence reserves one load-data FIFO slot up front so that
    // returning data can never find the FIFO full.
    assign ar_room       = (ar_idx_q != '0) || ((CNT_W'(ldf_occ) + infl_q) < CNT_W'(DEPTH));
    assign mbus_ar_valid = !req_empty && (out_q < OUT_W'(MAX_OUTSTANDING)) && ar_room;
    assign mbus_ar_addr  = req_mem[req_rd_q[FIFO_DEPTH_BITS-1:0]]
                         + MBUS_ADDR_WIDTH'(ar_idx_q) * MBUS_ADDR_WIDTH'(MBUS_DW_B);
    assign ar_hs    = mbus_ar_valid && mbus_ar_ready;
    assign ar_start = ar_hs && (ar_idx_q == '0);
    assign req_pop  = ar_hs && (ar_idx_q == IDX_LAST);

    assign mbus_r_ready = (out_q != '0);
    assign r_hs         = mbus_r_valid && mbus_r_ready;
    assign ldf_push     = r_hs && (r_idx_q == IDX_LAST);

    always_comb begin
        asm_d = asm_q;
        if (r_hs) begin
            asm_d[int'(r_idx_q) * MBUS_DATA_WIDTH +: MBUS_DATA_WIDTH] = mbus_r_data;
        end
    end

    assign rvv_valid_in = !ldf_empty && rvv_ready_out;
    assign ldf_pop      = rvv_valid_in;
    assign rvv_data_in  = ldf_empty ? '0 : ldf_mem[ldf_rd_q[FIFO_DEPTH_BITS-1:0]];

    // ---------------- store path ----------------
    assign st_empty    = (st_wr_q == st_rd_q);
    assign st_full     = ((st_wr_q - st_rd_q) == PTR_W'(DEPTH));
    assign rvv_st_full = st_full;
    assign st_push     = rvv_valid_out && !st_full;
    assign st_be_h     = st_empty ? '0 : st_be_mem[st_rd_q[FIFO_DEPTH_BITS-1:0]];

    // Lowest non-empty sub-beat at or after st_idx_q; st_more says another follows.
    always_comb begin
        st_pend = 1'b0;
        st_more = 1'b0;
        st_cur  = '0;
        for (int k = R - 1; k >= 0; k--) begin
            if (k >= int'(st_idx_q) && st_be_h[k*MBUS_DW_B +: MBUS_DW_B] != '0) begin
                st_more = st_pend;
                st_pend = 1'b1;
                st_cur  = IDX_W'(k);
            end
        end
    end

    assign mbus_aw_valid = st_pend;
    assign mbus_w_valid  = st_pend;
    assign mbus_aw_addr  = st_addr_mem[st_rd_q[FIFO_DEPTH_BITS-1:0]]
                         + MBUS_ADDR_WIDTH'(st_cur) * MBUS_ADDR_WIDTH'(MBUS_DW_B);
    assign mbus_w_data   = st_data_mem[st_rd_q[FIFO_DEPTH_BITS-1:0]][int'(st_cur) * MBUS_DATA_WIDTH +: MBUS_DATA_WIDTH];
    assign mbus_w_strb   = st_be_h[int'(st_cur) * MBUS_DW_B +: MBUS_DW_B];
    assign st_hs         = st_pend && mbus_aw_ready && mbus_w_ready;
    assign st_pop        = (!st_empty && !st_pend) || (st_hs && !st_more);

    assign mbus_b_ready = (wr_q > ack_q);
    assign b_hs         = mbus_b_valid && mbus_b_ready;

    // ---------------- next state ----------------
    always_comb begin
        req_wr_d = req_wr_q + PTR_W'(req_push);
        req_rd_d = req_rd_q + PTR_W'(req_pop);
        ldf_wr_d = ldf_wr_q + PTR_W'(ldf_push);
        ldf_rd_d = ldf_rd_q + PTR_W'(ldf_pop);
        st_wr_d  = st_wr_q + PTR_W'(st_push);
        st_rd_d  = st_rd_q + PTR_W'(st_pop);
        ar_idx_d = ar_hs ? ((ar_idx_q == IDX_LAST) ? '0 : ar_idx_q + 1'b1) : ar_idx_q;
        r_idx_d  = r_hs ? ((r_idx_q == IDX_LAST) ? '0 : r_idx_q + 1'b1) : r_idx_q;
        st_idx_d = st_pop ? '0 : (st_hs ? st_cur + 1'b1 : st_idx_q);
        out_d    = out_q + OUT_W'(ar_hs) - OUT_W'(r_hs);
        infl_d   = infl_q + CNT_W'(ar_start) - CNT_W'(ldf_push);

        // Done pulses are evaluated on next-state values so the pulse and the
        // counter clear land in the same cycle.
        ld_req_nxt = ld_req_q + CNT_W'(req_push);
        ld_del_nxt = ld_del_q + CNT_W'(ldf_pop);
        done_ld_d  = (ld_req_nxt == ld_del_nxt) && (ld_req_nxt != '0)
                  && (req_wr_d == req_rd_d) && (out_d == '0);
        ld_req_d   = done_ld_d ? '0 : ld_req_nxt;
        ld_del_d   = done_ld_d ? '0 : ld_del_nxt;

        wr_nxt    = wr_q + CNT_W'(st_hs);
        ack_nxt   = ack_q + CNT_W'(b_hs);
        done_st_d = (wr_nxt == ack_nxt) && (wr_nxt != '0) && (st_wr_d == st_rd_d);
        wr_d      = done_st_d ? '0 : wr_nxt;
        ack_d     = done_st_d ? '0 : ack_nxt;

        if (b_hs && mbus_b_resp != 2'b00) begin
            st_err_d = 1'b1;
        end else if (done_st_q) begin
            st_err_d = 1'b0;
        end else begin
            st_err_d = st_err_q;
        end
    end

    assign rvv_done_ld = done_ld_q;
    assign rvv_done_st = done_st_q;
    assign rvv_st_err  = st_err_q;

    always_ff @(posedge clk) begin
        if (req_push) req_mem[req_wr_q[FIFO_DEPTH_BITS-1:0]] <= rvv_addr_out;
        if (ldf_push) ldf_mem[ldf_wr_q[FIFO_DEPTH_BITS-1:0]] <= asm_d;
        if (st_push) begin
            st_addr_mem[st_wr_q[FIFO_DEPTH_BITS-1:0]] <= rvv_addr_out;
            st_data_mem[st_wr_q[FIFO_DEPTH_BITS-1:0]] <= rvv_data_out;
            st_be_mem[st_wr_q[FIFO_DEPTH_BITS-1:0]]   <= rvv_be_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_wr_q  <= '0;  req_rd_q <= '0;
            ldf_wr_q  <= '0;  ldf_rd_q <= '0;
            st_wr_q   <= '0;  st_rd_q  <= '0;
            ar_idx_q  <= '0;  r_idx_q  <= '0;  st_idx_q <= '0;
            out_q     <= '0;  infl_q   <= '0;
            ld_req_q  <= '0;  ld_del_q <= '0;
            wr_q      <= '0;  ack_q    <= '0;
            asm_q     <= '0;
            done_ld_q <= 1'b0;
            done_st_q <= 1'b0;
            st_err_q  <= 1'b0;
        end else begin
            req_wr_q  <= req_wr_d;  req_rd_q <= req_rd_d;
            ldf_wr_q  <= ldf_wr_d;  ldf_rd_q <= ldf_rd_d;
            st_wr_q   <= st_wr_d;   st_rd_q  <= st_rd_d;
            ar_idx_q  <= ar_idx_d;  r_idx_q  <= r_idx_d;  st_idx_q <= st_idx_d;
            out_q     <= out_d;     infl_q   <= infl_d;
            ld_req_q  <= ld_req_d;  ld_del_q <= ld_del_d;
            wr_q      <= wr_d;      ack_q    <= ack_d;
            asm_q     <= asm_d;
            done_ld_q <= done_ld_d;
            done_st_q <= done_st_d;
            st_err_q  <= st_err_d;
        end
    end
endmodule
